// File: rtl/vga_stream_decoder.sv
// VGA sync/pixel receiver: rebuilds x/y and active-video from hs/vs, checks line and
// frame timing, and reports lock. Output is two cycles behind the input pixel.
module vga_stream_decoder #(
  parameter int unsigned HOR_TOTAL       = 1344,
  parameter int unsigned HOR_ACTIVE      = 1024,
  parameter int unsigned HOR_SYNC_START  = 1048,
  parameter int unsigned VER_TOTAL       = 806,
  parameter int unsigned VER_ACTIVE      = 768,
  parameter int unsigned VER_SYNC_START  = 771,
  parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic        locked,
  output logic        de,
  output logic        frame_start,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic        POL   = 1'(SYNC_ACTIVE_LOW);
  localparam logic [10:0] HT_M1 = 11'(HOR_TOTAL - 1);
  localparam logic [10:0] HA    = 11'(HOR_ACTIVE);
  localparam logic [10:0] HSS   = 11'(HOR_SYNC_START);
  localparam logic [10:0] VT    = 11'(VER_TOTAL);
  localparam logic [10:0] VT_M1 = 11'(VER_TOTAL - 1);
  localparam logic [10:0] VA    = 11'(VER_ACTIVE);
  localparam logic [10:0] VSS   = 11'(VER_SYNC_START);

  logic        hs1_q, vs1_q, hsp_q, vsp_q;
  logic [11:0] rgb1_q, rgb2_q;
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [10:0] plen_q, plen_d, lcnt_q, lcnt_d;
  logic [1:0]  state_q, state_d;
  logic        bad_q, bad_d;
  logic [7:0]  err_q, err_d;
  logic        locked_q;

  logic hs_edge, vs_edge, hwrap, line_err, frame_err;

  assign hs_edge = hs1_q & ~hsp_q;
  assign vs_edge = vs1_q & ~vsp_q;
  assign hwrap   = (hcnt_q == HT_M1);

  // A missing edge is seen once, when plen sits at HT-1 without an edge; plen then runs on to saturation.
  assign line_err  = hs_edge ? (plen_q != HT_M1) : (plen_q == HT_M1);
  assign frame_err = vs_edge && (lcnt_q != VT);

  always_comb begin
    hcnt_d = hs_edge ? HSS : (hwrap ? '0 : hcnt_q + 11'd1);

    vcnt_d = vcnt_q;
    if (vs_edge)
      vcnt_d = VSS;
    else if (!hs_edge && hwrap)
      vcnt_d = (vcnt_q == VT_M1) ? '0 : vcnt_q + 11'd1;

    plen_d = hs_edge ? '0 : ((plen_q == '1) ? plen_q : plen_q + 11'd1);

    lcnt_d = lcnt_q;
    if (vs_edge)
      lcnt_d = '0;
    else if (hs_edge && lcnt_q != '1)
      lcnt_d = lcnt_q + 11'd1;
  end

  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (vs_edge) begin
          state_d = ALIGN;
          bad_d   = 1'b0;
        end
      end
      ALIGN: begin
        if (vs_edge) begin
          if (lcnt_q == VT && !bad_q && !line_err)
            state_d = LOCKED;
          bad_d = 1'b0;
        end else if (line_err) begin
          bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (line_err || frame_err) begin
          state_d = IDLE;
          if (err_q != '1)
            err_d = err_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      hsp_q    <= 1'b0;
      vsp_q    <= 1'b0;
      rgb1_q   <= '0;
      rgb2_q   <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      plen_q   <= '0;
      lcnt_q   <= '0;
      state_q  <= IDLE;
      bad_q    <= 1'b0;
      err_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      hs1_q    <= hs_in ^ POL;
      vs1_q    <= vs_in ^ POL;
      hsp_q    <= hs1_q;
      vsp_q    <= vs1_q;
      rgb1_q   <= {r_in, g_in, b_in};
      rgb2_q   <= rgb1_q;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      plen_q   <= plen_d;
      lcnt_q   <= lcnt_d;
      state_q  <= state_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      locked_q <= (state_q == LOCKED);
    end
  end

  // hcnt/vcnt are updated from the stage-1 pixel, so they already describe the stage-2 pixel.
  assign xpos        = hcnt_q;
  assign ypos        = vcnt_q;
  assign locked      = locked_q;
  assign de          = locked_q && (hcnt_q < HA) && (vcnt_q < VA);
  assign frame_start = de && (hcnt_q == '0) && (vcnt_q == '0);
  assign r_out       = de ? rgb2_q[11:8] : '0;
  assign g_out       = de ? rgb2_q[7:4]  : '0;
  assign b_out       = de ? rgb2_q[3:0]  : '0;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_vga_stream_decoder.sv
// Directed bench for vga_stream_decoder on a reduced 12x6 raster (sync at x=8..9, line 4).
module tb_vga_stream_decoder;

  localparam int unsigned HT   = 12;
  localparam int unsigned HA   = 6;
  localparam int unsigned HSS  = 8;
  localparam int unsigned HSW  = 2;
  localparam int unsigned VT   = 6;
  localparam int unsigned VA   = 3;
  localparam int unsigned VSS  = 4;
  localparam int unsigned NONE = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_in, vs_in;
  logic [3:0]  r_in, g_in, b_in;
  logic        locked, de, frame_start;
  logic [10:0] xpos, ypos;
  logic [3:0]  r_out, g_out, b_out;
  logic [7:0]  err_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned frm = 0;
  int unsigned rise_cnt = 0, fall_cnt = 0, de_cnt = 0, fs_cnt = 0, nz_cnt = 0;
  logic [21:0] rise_xy = '0, fall_xy = '0, fs_xy = '0;
  logic [34:0] nz_rec [4];
  logic        prev_l = 1'b0;

  vga_stream_decoder #(
    .HOR_TOTAL(HT), .HOR_ACTIVE(HA), .HOR_SYNC_START(HSS),
    .VER_TOTAL(VT), .VER_ACTIVE(VA), .VER_SYNC_START(VSS),
    .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .locked(locked), .de(de), .frame_start(frame_start),
    .xpos(xpos), .ypos(ypos),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .err_cnt(err_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int unsigned f, input int unsigned x, input int unsigned y);
    if (f == 2 && x == 3 && y == 1) return 12'hF00;
    if (f == 2 && x == 7 && y == 1) return 12'hFFF;
    if (f == 2 && x == 4 && y == 2) return 12'h0A5;
    if (f == 11 && x == 4 && y == 2) return 12'h789;
    return 12'h000;
  endfunction

  // One frame of active-low syncs; optionally drops the last pixel of short_y, suppresses hs on nohs_y,
  // or pulses rst around pixel (6,2).
  task automatic run_frame(input int unsigned first_y, input int unsigned short_y,
                           input int unsigned nohs_y, input bit do_rst);
    for (int unsigned y = first_y; y < VT; y++) begin
      for (int unsigned x = 0; x < HT; x++) begin
        if (!(y == short_y && x == HT - 1)) begin
          @(negedge clk);
          if (do_rst && y == 2 && x == 6) begin
            check("pre_rst", 64'({de, xpos, ypos, r_out, g_out, b_out, err_cnt}),
                  64'({1'b1, 11'd4, 11'd2, 12'h789, 8'd3}));
            rst = 1'b1;
            #1;
            check("rst_async", 64'({locked, de, frame_start, xpos, ypos, r_out, g_out, b_out, err_cnt}), 64'd0);
          end
          if (do_rst && y == 3 && x == 0) rst = 1'b0;
          hs_in = !(x >= HSS && x < HSS + HSW && y != nohs_y);
          vs_in = !(y == VSS);
          {r_in, g_in, b_in} = pix(frm, x, y);
        end
      end
    end
    frm++;
  endtask

  initial forever begin
    @(posedge clk);
    #3;
    if (!rst) begin
      if (locked && !prev_l) begin rise_cnt++; rise_xy = {xpos, ypos}; end
      if (!locked && prev_l) begin fall_cnt++; fall_xy = {xpos, ypos}; end
      if (de) de_cnt++;
      if (frame_start) begin
        if (fs_cnt == 0) fs_xy = {xpos, ypos};
        fs_cnt++;
      end
      if ({r_out, g_out, b_out} != 12'h000) begin
        if (nz_cnt < 4) nz_rec[nz_cnt[1:0]] = {xpos, ypos, r_out, g_out, b_out, de};
        nz_cnt++;
      end
    end
    prev_l = locked;
  end

  initial begin
    rst = 1'b1;
    hs_in = 1'b1;
    vs_in = 1'b1;
    {r_in, g_in, b_in} = 12'h000;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({locked, de, frame_start, xpos, ypos, r_out, g_out, b_out, err_cnt}), 64'd0);
    rst = 1'b0;

    run_frame(0, NONE, NONE, 1'b0);                       // F0: first vs -> ALIGN
    check("no_lock_f0", 64'(rise_cnt), 64'd0);
    run_frame(0, NONE, NONE, 1'b0);                       // F1: second vs -> LOCKED
    check("lock_rise", 64'(rise_cnt), 64'd1);
    check("lock_rise_xy", 64'(rise_xy), 64'({11'd1, 11'd4}));
    check("locked_f1", 64'(locked), 64'd1);
    check("no_fs_yet", 64'(fs_cnt), 64'd0);

    run_frame(0, NONE, NONE, 1'b0);                       // F2: pixel injection
    check("fs_count", 64'(fs_cnt), 64'd1);
    check("fs_xy", 64'(fs_xy), 64'd0);
    check("de_per_frame", 64'(de_cnt), 64'd18);
    check("nz_count", 64'(nz_cnt), 64'd2);
    check("nz_red", 64'(nz_rec[0]), 64'({11'd3, 11'd1, 12'hF00, 1'b1}));
    check("nz_gb", 64'(nz_rec[1]), 64'({11'd4, 11'd2, 12'h0A5, 1'b1}));

    run_frame(0, NONE, 1, 1'b0);                          // F3: hs missing on line 1
    check("miss_fall", 64'(fall_cnt), 64'd1);
    check("miss_fall_xy", 64'(fall_xy), 64'({11'd9, 11'd1}));
    check("miss_err", 64'(err_cnt), 64'd1);
    check("miss_unlocked", 64'(locked), 64'd0);
    run_frame(0, NONE, NONE, 1'b0);                       // F4: relock
    check("relock", 64'(rise_cnt), 64'd2);
    check("relock_xy", 64'(rise_xy), 64'({11'd1, 11'd4}));
    check("idle_err_uncounted", 64'(err_cnt), 64'd1);

    run_frame(0, 1, NONE, 1'b0);                          // F5: line 1 one cycle short
    check("short_fall", 64'(fall_cnt), 64'd2);
    check("short_fall_xy", 64'(fall_xy), 64'({11'd9, 11'd2}));
    check("short_err", 64'(err_cnt), 64'd2);
    run_frame(0, NONE, NONE, 1'b0);                       // F6: relock
    check("relock2", 64'(rise_cnt), 64'd3);
    run_frame(1, NONE, NONE, 1'b0);                       // F7: 5-line frame
    check("frame_fall", 64'(fall_cnt), 64'd3);
    check("frame_fall_xy", 64'(fall_xy), 64'({11'd1, 11'd4}));
    check("frame_err", 64'(err_cnt), 64'd3);

    run_frame(0, NONE, NONE, 1'b0);                       // F8: -> ALIGN
    run_frame(0, 1, NONE, 1'b0);                          // F9: short line during ALIGN
    check("align_bad_nolock", 64'(rise_cnt), 64'd3);
    check("align_err_uncounted", 64'(err_cnt), 64'd3);
    check("align_unlocked", 64'(locked), 64'd0);
    run_frame(0, NONE, NONE, 1'b0);                       // F10: lock after clean frame
    check("relock3", 64'(rise_cnt), 64'd4);

    run_frame(0, NONE, NONE, 1'b1);                       // F11: async reset mid-frame
    run_frame(0, NONE, NONE, 1'b0);                       // F12: relock after reset
    check("post_rst_lock", 64'(rise_cnt), 64'd5);
    check("post_rst_lock_xy", 64'(rise_xy), 64'({11'd1, 11'd4}));
    check("post_rst_err", 64'(err_cnt), 64'd0);

    for (int unsigned i = 0; i < 260; i++) begin
      run_frame(0, 4, NONE, 1'b0);                        // lock at vs, then short line 4
      run_frame(0, NONE, NONE, 1'b0);
      if (i == 253) check("err_254", 64'(err_cnt), 64'd254);
      if (i == 254) check("err_255", 64'(err_cnt), 64'd255);
    end
    check("err_saturated", 64'(err_cnt), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
